// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: framed byte stream -> big-endian 16-bit writes.
// Optional checksum byte after the payload is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int unsigned INST_ADDR_WIDTH     = 16,
  parameter int unsigned INST_DATA_BIT_WIDTH = 16,
  parameter int unsigned INST_MEM_SIZE       = 26,
  parameter int unsigned NUM_BYTES_IN_INST   = 2,
  parameter logic [7:0]  SYNC_BYTE           = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           wr_en,
  output logic [INST_ADDR_WIDTH-1:0]     wr_addr,
  output logic [INST_DATA_BIT_WIDTH-1:0] wr_data,
  output logic                           cpu_hold,
  output logic                           done,
  output logic                           error,
  output logic [1:0]                     err_code,
  output logic [INST_ADDR_WIDTH-1:0]     words_loaded
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } state_t;

  localparam logic [INST_ADDR_WIDTH-1:0] STRIDE  = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
  localparam logic [15:0]                MAX_CNT = 16'(INST_MEM_SIZE);

  state_t                           state_q, state_d;
  logic [15:0]                      count_q, count_d;
  logic [7:0]                       hi_q, hi_d;
  logic [INST_ADDR_WIDTH-1:0]       index_q, index_d;
  logic [INST_ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
  logic [INST_DATA_BIT_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [1:0]                       err_code_q, err_code_d;
  logic                             in_ready_q, in_ready_d;
  logic                             wr_en_q;
  logic                             cpu_hold_q;
  logic                             done_q;
  logic                             error_q;
  logic                             accept;
  logic                             last_word;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]                       csum_q, csum_d;
  localparam state_t AFTER_PAYLOAD = CHECK;
`else
  localparam state_t AFTER_PAYLOAD = DONE;
`endif

  assign accept    = in_valid && in_ready_q;
  assign last_word = (32'(index_q) + 32'd1) == 32'(count_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    index_d    = index_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC_BYTE) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          count_d = {in_data, count_q[7:0]};
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          count_d = {count_q[15:8], in_data};
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          if (count_d > MAX_CNT) begin
            state_d    = ERROR;
            err_code_d = 2'b01;
          end else if (count_d == 16'd0) begin
            state_d = AFTER_PAYLOAD;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        // The write word and address are captured here so they are valid with wr_en.
        if (accept) begin
          wr_data_d = {hi_q, in_data};
          wr_addr_d = index_q * STRIDE;
`ifdef INST_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ in_data;
`endif
          state_d   = WRITE;
        end
      end
      WRITE: begin
        index_d = index_q + 1'b1;
        state_d = last_word ? AFTER_PAYLOAD : DATA_HI;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERROR;
            err_code_d = 2'b10;
          end
        end
      end
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase

    case (state_d)
      WRITE, DONE, ERROR: in_ready_d = 1'b0;
      default:            in_ready_d = 1'b1;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      index_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_code_q <= '0;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      index_q    <= index_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_code_q <= err_code_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= (state_d == WRITE);
      cpu_hold_q <= (state_d != DONE);
      done_q     <= (state_d == DONE);
      error_q    <= (state_d == ERROR);
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign words_loaded = index_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus pushes expected writes, a negedge monitor checks them.
module tb_inst_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error), .err_code(err_code), .words_loaded(words_loaded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    logic [31:0] e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {16'h0, wr_addr}, {16'h0, e[31:16]});
        check("wr_data", {16'h0, wr_data}, {16'h0, e[15:0]});
      end
    end
    if (done === 1'b1 && error === 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_and_error: got both 1 required not both");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int waitc;
    if (gaps) begin
      g = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (g) begin
        in_data = 8'($urandom);
        tick();
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    waitc    = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: got in_ready 0 for byte %0h expected 1", b);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_term();
    int c;
    c = 0;
    while (!(done || error) && c < 200) begin
      tick();
      c++;
    end
    if (!(done || error)) begin
      n_vec++;
      n_miss++;
      $display("FAIL term_timeout: got done=%0b error=%0b expected one set", done, error);
    end
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Sends a frame of n words, word k = base + k*0x0111, with its expected writes queued.
  task automatic load_words(input int n, input logic [15:0] base, input bit gaps);
    logic [15:0] w;
    logic [15:0] nn;
    logic [7:0]  cs;
    nn = 16'(n);
    cs = nn[15:8] ^ nn[7:0];
    send_byte(8'hA5, gaps);
    send_byte(nn[15:8], gaps);
    send_byte(nn[7:0], gaps);
    for (int k = 0; k < n; k++) begin
      w = base + 16'(k) * 16'h0111;
      exp_q.push_back({16'(k * 2), w});
      cs = cs ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(cs, gaps);
`else
    if (cs == 8'h00) in_data = 8'h00;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s2 [$];
    // Reset and idle
    do_reset();
    repeat (5) tick();
    check("rst_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);

    // Two-word frame with leading junk bytes
    s2 = '{8'h00, 8'h13, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef INST_LOADER_CHECKSUM_EN
    s2.push_back(8'h42);  // 00^02^12^34^AB^CD
`endif
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0002, 16'hABCD});
    foreach (s2[i]) send_byte(s2[i], 1'b0);
    wait_term();
    check("t2_done", {31'h0, done}, 32'h1);
    check("t2_cpu_hold", {31'h0, cpu_hold}, 32'h0);
    check("t2_words", {16'h0, words_loaded}, 32'h2);
    check("t2_error", {31'h0, error}, 32'h0);
    check("t2_pending", exp_q.size(), 32'h0);

    // Length overflow
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h1B, 1'b0);
    wait_term();
    check("t3_error", {31'h0, error}, 32'h1);
    check("t3_err_code", {30'h0, err_code}, 32'h1);
    check("t3_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    check("t3_done", {31'h0, done}, 32'h0);
    check("t3_words", {16'h0, words_loaded}, 32'h0);

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum mismatch: FE expected, 00 sent
    do_reset();
    exp_q.push_back({16'h0000, 16'hFF00});
    s2 = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00};
    foreach (s2[i]) send_byte(s2[i], 1'b0);
    wait_term();
    check("t4_error", {31'h0, error}, 32'h1);
    check("t4_err_code", {30'h0, err_code}, 32'h2);
    check("t4_pending", exp_q.size(), 32'h0);
`endif

    // Reset after the second of three writes, with ragged in_valid
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    exp_q.push_back({16'h0000, 16'hC001});
    exp_q.push_back({16'h0002, 16'hC002});
    send_byte(8'hC0, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hC0, 1'b1);
    send_byte(8'h02, 1'b1);
    rst = 1'b1;
    tick();
    check("t5_wr_en", {31'h0, wr_en}, 32'h0);
    check("t5_in_ready", {31'h0, in_ready}, 32'h1);
    check("t5_cpu_hold", {31'h0, cpu_hold}, 32'h1);
    check("t5_wr_addr", {16'h0, wr_addr}, 32'h0);
    check("t5_wr_data", {16'h0, wr_data}, 32'h0);
    check("t5_words", {16'h0, words_loaded}, 32'h0);
    check("t5_done_err", {30'h0, done, error}, 32'h0);
    check("t5_err_code", {30'h0, err_code}, 32'h0);
    check("t5_pending", exp_q.size(), 32'h0);
    tick();
    rst = 1'b0;
    load_words(3, 16'h5A00, 1'b0);
    wait_term();
    check("t5b_done", {31'h0, done}, 32'h1);
    check("t5b_words", {16'h0, words_loaded}, 32'h3);
    check("t5b_pending", exp_q.size(), 32'h0);

    // Maximum length frame, then a byte offered after DONE
    do_reset();
    load_words(26, 16'h1000, 1'b0);
    wait_term();
    check("t6_done", {31'h0, done}, 32'h1);
    check("t6_words", {16'h0, words_loaded}, 32'd26);
    check("t6_last_addr", {16'h0, wr_addr}, 32'd50);
    check("t6_pending", exp_q.size(), 32'h0);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (3) tick();
    check("t6_in_ready", {31'h0, in_ready}, 32'h0);
    check("t6_words_after", {16'h0, words_loaded}, 32'd26);
    check("t6_done_after", {31'h0, done}, 32'h1);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
